wb_port_arbiter: RTL and testbench

//   Shares the single register-file write port between the in-order pipeline writeback
//   (MEM/WB stage output, after the MemtoReg mux) and a long-latency unit (mult/div) that

---
 rtl/wb_port_arbiter_if.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if
//   Signal bundle around the register-file write-port arbiter.
//   slave  modport : the arbiter's view (pipeline/long-unit in, rf write out)
//   master modport : the surrounding core's view (drives pipeline/long-unit)
//   Signals:
//     wb_we_i/wb_dst_i/wb_data_i     pipeline writeback (MEM/WB stage)
//     lu_valid_i/lu_ready_o          long-unit result handshake
//     lu_dst_i/lu_data_i             long-unit result payload
//     rf_we_o/rf_addr_o/rf_wdata_o   register-file write port
//     stall_o                        freeze MEM/WB and upstream for one slot
//     pend_cnt_o                     buffered long-unit results
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if #(
   parameter int DEPTH = 2,
   parameter int DW    = 32,
   parameter int AW    = 5
);
   logic                         wb_we_i;
   logic [AW-1:0]                wb_dst_i;
   logic [DW-1:0]                wb_data_i;
   logic                         lu_valid_i;
   logic                         lu_ready_o;
   logic [AW-1:0]                lu_dst_i;
   logic [DW-1:0]                lu_data_i;
   logic                         rf_we_o;
   logic [AW-1:0]                rf_addr_o;
   logic [DW-1:0]                rf_wdata_o;
   logic                         stall_o;
   logic [$clog2(DEPTH+1)-1:0]   pend_cnt_o;

   modport slave (
      input  wb_we_i, wb_dst_i, wb_data_i,
      input  lu_valid_i, lu_dst_i, lu_data_i,
      output lu_ready_o,
      output rf_we_o, rf_addr_o, rf_wdata_o,
      output stall_o, pend_cnt_o
   );

   modport master (
      output wb_we_i, wb_dst_i, wb_data_i,
      output lu_valid_i, lu_dst_i, lu_data_i,
      input  lu_ready_o,
      input  rf_we_o, rf_addr_o, rf_wdata_o,
      input  stall_o, pend_cnt_o
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback and a long-latency unit (mult/div). Pipeline writes win; long-unit
//   results queue in a small FIFO and drain into idle slots. If the FIFO head
//   waits MAX_WAIT cycles, stall_o steals one slot from the pipeline for it.
//
//   Ports:
//     clk  clock
//     rst  synchronous, active-high reset (drops all buffered results)
//     bus  wb_port_arbiter_if.slave (pipeline writeback, long-unit handshake,
//          register-file write port, stall_o, pend_cnt_o)
//
//   Build option:
//     WB_BYPASS_EN  when defined, a result accepted while the FIFO is empty and
//                   the port is free is written in the same cycle (latency 0)
//                   instead of being pushed.
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4,
   parameter int DW       = 32,
   parameter int AW       = 5
) (
   input logic             clk,
   input logic             rst,
   wb_port_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int WW = $clog2(MAX_WAIT+1);
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

   logic [AW-1:0] dst_mem_r  [DEPTH];
   logic [DW-1:0] data_mem_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [WW-1:0] wait_cnt_r;

   logic          empty_s;
   logic          full_s;
   logic          stall_s;
   logic          pipe_we_s;
   logic          lu_nz_s;
   logic          accept_s;
   logic          bypass_ok_s;
   logic          bypass_s;
   logic          push_s;
   logic          pop_s;
   logic          we_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] wdata_s;

   assign empty_s   = (count_r == {CW{1'b0}});
   assign full_s    = (count_r == DEPTH_C);
   assign stall_s   = !empty_s && (wait_cnt_r >= MAX_WAIT_C);
   // A pipeline write to r0 is dropped, so it leaves the slot free.
   assign pipe_we_s = bus.wb_we_i && (bus.wb_dst_i != {AW{1'b0}});
   assign lu_nz_s   = (bus.lu_dst_i != {AW{1'b0}});
   assign accept_s  = !rst && bus.lu_valid_i && !full_s;

`ifdef WB_BYPASS_EN
   // Only reached in the grant when the FIFO is empty and the port is free.
   assign bypass_ok_s = accept_s && lu_nz_s;
`else
   assign bypass_ok_s = 1'b0;
`endif

   // r0 results are accepted but never stored; bypassed results skip the FIFO.
   assign push_s = accept_s && lu_nz_s && !bypass_s;

   // Write-port grant: starved head, then pipeline, then FIFO head, then bypass.
   always_comb begin
      we_s     = 1'b0;
      addr_s   = {AW{1'b0}};
      wdata_s  = {DW{1'b0}};
      pop_s    = 1'b0;
      bypass_s = 1'b0;
      if (rst) begin
         we_s = 1'b0;
      end else if (stall_s) begin
         we_s    = 1'b1;
         addr_s  = dst_mem_r[rd_ptr_r];
         wdata_s = data_mem_r[rd_ptr_r];
         pop_s   = 1'b1;
      end else if (pipe_we_s) begin
         we_s    = 1'b1;
         addr_s  = bus.wb_dst_i;
         wdata_s = bus.wb_data_i;
      end else if (!empty_s) begin
         we_s    = 1'b1;
         addr_s  = dst_mem_r[rd_ptr_r];
         wdata_s = data_mem_r[rd_ptr_r];
         pop_s   = 1'b1;
      end else if (bypass_ok_s) begin
         we_s     = 1'b1;
         addr_s   = bus.lu_dst_i;
         wdata_s  = bus.lu_data_i;
         bypass_s = 1'b1;
      end else begin
         we_s = 1'b0;
      end
   end

   // FIFO pointers, occupancy and the head starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r   <= {PW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         wait_cnt_r <= {WW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
         // Counts only while the same entry sits at the head unserved.
         if (pop_s || empty_s) begin
            wait_cnt_r <= {WW{1'b0}};
         end else if (wait_cnt_r < MAX_WAIT_C) begin
            wait_cnt_r <= wait_cnt_r + WW'(1'b1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   // FIFO payload storage; contents are don't-care while unoccupied.
   always_ff @(posedge clk) begin
      if (push_s) begin
         dst_mem_r[wr_ptr_r]  <= bus.lu_dst_i;
         data_mem_r[wr_ptr_r] <= bus.lu_data_i;
      end
   end

   assign bus.lu_ready_o = !rst && !full_s;
   assign bus.stall_o    = !rst && stall_s;
   assign bus.rf_we_o    = we_s;
   assign bus.rf_addr_o  = addr_s;
   assign bus.rf_wdata_o = wdata_s;
   assign bus.pend_cnt_o = count_r;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Self-checking bench for wb_port_arbiter. A queue-based reference model
//   predicts register-file writes (with their cycle) and per-cycle status;
//   a negedge monitor compares the DUT against those predictions.
//   Honours WB_BYPASS_EN when defined for the build.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;
   localparam int DW       = 32;
   localparam int AW       = 5;
`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_port_arbiter_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

   wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { logic [AW-1:0] dst; logic [DW-1:0] data; } res_t;
   typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
   typedef struct { int cyc; bit ready; bit stall; bit chk_pend; int pend; } st_t;

   res_t fifo_q[$];
   wr_t  wr_q[$];
   st_t  st_q[$];
   int   head_since = 0;
   int   cyc = 0;
   bit   run = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Drive one cycle, predict its outcome, then advance past the clock edge.
   task automatic apply(input bit r, input bit we, input logic [AW-1:0] wd,
                        input logic [DW-1:0] wdat, input bit lv,
                        input logic [AW-1:0] ld, input logic [DW-1:0] ldat,
                        output bit acc, output bit stl);
      bit rdy, was_empty, popped, byp;
      cyc++;
      rst            = r;
      bus.wb_we_i    = we;
      bus.wb_dst_i   = wd;
      bus.wb_data_i  = wdat;
      bus.lu_valid_i = lv;
      bus.lu_dst_i   = ld;
      bus.lu_data_i  = ldat;
      acc = 1'b0; stl = 1'b0; popped = 1'b0; byp = 1'b0;
      if (r) begin
         fifo_q.delete();
         st_q.push_back('{cyc, 1'b0, 1'b0, 1'b0, 0});
      end else begin
         was_empty = (fifo_q.size() == 0);
         rdy = (fifo_q.size() < DEPTH);
         stl = !was_empty && ((cyc - head_since) >= MAX_WAIT);
         acc = lv && rdy;
         st_q.push_back('{cyc, rdy, stl, 1'b1, fifo_q.size()});
         if (stl || (!(we && wd != 0) && !was_empty)) begin
            wr_q.push_back('{cyc, fifo_q[0].dst, fifo_q[0].data});
            void'(fifo_q.pop_front());
            popped = 1'b1;
         end else if (we && wd != 0) begin
            wr_q.push_back('{cyc, wd, wdat});
         end else if (BYPASS && acc && ld != 0) begin
            wr_q.push_back('{cyc, ld, ldat});
            byp = 1'b1;
         end
         if (acc && ld != 0 && !byp) fifo_q.push_back('{ld, ldat});
         // An entry reaching the head starts waiting from the next cycle.
         if (fifo_q.size() > 0 && (popped || was_empty)) head_since = cyc + 1;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: status every cycle, writes matched against predicted cycle.
   always @(negedge clk) begin : mon
      st_t s;
      wr_t e;
      if (run) begin
         if (st_q.size() == 0) begin
            chk("status_queue_empty", 1, 0);
         end else begin
            s = st_q.pop_front();
            chk("lu_ready_o", bus.lu_ready_o, s.ready);
            chk("stall_o", bus.stall_o, s.stall);
            if (s.chk_pend) chk("pend_cnt_o", bus.pend_cnt_o, s.pend);
         end
         while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            e = wr_q.pop_front();
            chk("missing_write_addr", 0, e.addr);
         end
         if (bus.rf_we_o) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
               e = wr_q.pop_front();
               chk("rf_addr_o", bus.rf_addr_o, e.addr);
               chk("rf_wdata_o", bus.rf_wdata_o, e.data);
            end else begin
               chk("unexpected_rf_we_o", 1, 0);
            end
         end else begin
            chk("idle_rf_addr_o", bus.rf_addr_o, 0);
            chk("idle_rf_wdata_o", bus.rf_wdata_o, 0);
         end
      end
   end

   initial begin
      bit acc, stl, lv, we, r;
      logic [AW-1:0] ld, wd;
      logic [DW-1:0] ldat, wdat;
      int busy_pct;
      bus.wb_we_i = 1'b0; bus.wb_dst_i = '0; bus.wb_data_i = '0;
      bus.lu_valid_i = 1'b0; bus.lu_dst_i = '0; bus.lu_data_i = '0;
      @(posedge clk);
      #1;
      run = 1'b1;

      // Reset with both requesters active.
      repeat (2) apply(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd7, 32'h2, acc, stl);
      // Idle port: push r7 then let it drain.
      apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, acc, stl);
      repeat (2) apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc, stl);
      // Priority and starvation: pipeline writes r3 every cycle, one push r9.
      apply(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd9, 32'h99, acc, stl);
      repeat (7) apply(1'b0, 1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'h0, acc, stl);
      // Full: two pushes while busy, third held until accepted.
      apply(1'b0, 1'b1, 5'd4, 32'hB, 1'b1, 5'd10, 32'h100, acc, stl);
      apply(1'b0, 1'b1, 5'd4, 32'hB, 1'b1, 5'd11, 32'h101, acc, stl);
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++)
         apply(1'b0, 1'b1, 5'd4, 32'hB, 1'b1, 5'd12, 32'h102, acc, stl);
      chk("held_result_accepted", acc, 1);
      repeat (12) apply(1'b0, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 32'h0, acc, stl);
      // r0 handling: head r5 drains during a pipeline r0 write; r0 result dropped.
      apply(1'b0, 1'b1, 5'd6, 32'hC, 1'b1, 5'd5, 32'h55, acc, stl);
      apply(1'b0, 1'b1, 5'd0, 32'hD, 1'b1, 5'd0, 32'h77, acc, stl);
      repeat (3) apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc, stl);
      // Reset mid-operation with two buffered results.
      apply(1'b0, 1'b1, 5'd8, 32'hE, 1'b1, 5'd13, 32'h130, acc, stl);
      apply(1'b0, 1'b1, 5'd8, 32'hE, 1'b1, 5'd14, 32'h140, acc, stl);
      apply(1'b1, 1'b1, 5'd8, 32'hE, 1'b0, 5'd0, 32'h0, acc, stl);
      repeat (4) apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc, stl);

      // Randomized traffic with varying pipeline load; long unit holds until accepted.
      lv = 1'b0; ld = '0; ldat = '0; we = 1'b0; wd = '0; wdat = '0; stl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         busy_pct = ((i / 500) % 3 == 0) ? 20 : (((i / 500) % 3 == 1) ? 60 : 95);
         if (!stl) begin
            we   = ($urandom_range(0, 99) < busy_pct);
            wd   = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
            wdat = $urandom;
         end
         if (!lv) begin
            lv   = ($urandom_range(0, 99) < 40);
            ld   = ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
            ldat = $urandom;
         end
         r = ($urandom_range(0, 199) == 0);
         apply(r, we, wd, wdat, lv, ld, ldat, acc, stl);
         if (acc || r) lv = 1'b0;
      end
      repeat (8) apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc, stl);

      run = 1'b0;
      while (wr_q.size() > 0) begin
         chk("undelivered_write_addr", 0, wr_q[0].addr);
         void'(wr_q.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
